row_input_ctrl: RTL and testbench
=================================

Name: row_input_ctrl

Overview:
- Feeds the systolic array's row inputs; the input-side counterpart of the column output controller.
- Accepts a serial stream of DW-bit words over a valid/ready write port and packs NROWS consecutive words into one row vector.
- Launches each vector into the array with diagonal skew: lane i gets element i exactly i advancing cycles after lane 0.
- Sits between the host/DMA write path and the array's left edge.

Parameters:
- NROWS, 8, number of array rows / output lanes (>=2).
- DW, 32, data word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- wvalid  in  1  writer has a word on win.
- win  in  DW  write data.
- wready  out  1  block accepts win this cycle.
- array_rdy  in  1  array advancing; 0 stalls the skew pipeline.
- out_r  out  NROWS x DW  per-lane row data, array [0:NROWS-1].
- out_v  out  NROWS  per-lane valid, bit i for lane i.
- busy  out  1  partial vector buffered, vector pending, or any out_v set.

Behaviour:
- Reset (rst=1 at posedge):
  - state=FILL, fill count=0.
  - Staging registers, all skew stages and out_r cleared to 0; out_v=0.
  - Any partial or pending vector is discarded.
  - wready=1 from the first cycle after reset deasserts.
- State machine, registered: FILL, LAUNCH.
  - FILL: wready=1. On wvalid&wready, win goes to staging[cnt] and cnt increments. The word that makes cnt==NROWS moves state to LAUNCH.
  - LAUNCH: wready=0. At the first edge with array_rdy=1, the staging vector enters skew stage 0 of every lane, cnt clears to 0 and state returns to FILL.
- wready is a function of registered state only; no combinational path from wvalid or array_rdy.
- Skew pipeline:
  - Lane i is a delay line of depth i+1 registers; out_r[i]/out_v[i] is its final register.
  - Pipeline advances only on edges with array_rdy=1. With array_rdy=0, all data and valids hold, including out_v.
  - An advancing edge with no launch shifts in valid=0; data shifts in unchanged value, treated as don't-care.
- Latency:
  - Last word of a vector accepted at edge k, array_rdy held high: launch at edge k+1.
  - out_v[0]=1 after edge k+1; out_v[i]=1 after edge k+1+i.
  - Each out_v[i] is high for exactly one advancing cycle per vector.
- Throughput: at most one vector per NROWS+1 cycles. Vectors never overlap within a lane. Consecutive vectors appear on lane i separated by the fill time.
- Boundaries:
  - wvalid while wready=0: word not consumed; the writer must hold it.
  - array_rdy low during LAUNCH: vector waits; no data lost.
  - array_rdy low mid-skew: diagonal shape is preserved, with relative lane offsets unchanged in advancing cycles.
  - rst asserted mid-vector or mid-skew: the reset behaviour above applies immediately at that edge.
- Word ordering: the first accepted word of a vector goes to lane 0, the last to lane NROWS-1.

Optional Feature:
- Macro ROW_IN_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 in FILL with cnt>0: state goes to LAUNCH; unfilled staging entries are zeroed with their lanes' valid launched as 0. Only lanes 0..cnt-1 assert out_v.
  - flush with cnt=0 is ignored.
  - A word accepted on the same edge as flush is included before padding.
  - flush in LAUNCH is ignored.
- Undefined: no flush port; partial vectors remain buffered until completed or reset.

Decomposition:
- Shared package systola_pkg holds:
  - DW and NROWS defaults.
  - Row-input state enum {FILL, LAUNCH}.
  - Word typedef logic [DW-1:0].
- Sub-module skew_line (parameter DEPTH, DW):
  - One lane's delay line with data and valid, and an advance enable.
  - Instantiated NROWS times with DEPTH=i+1 via generate.

Test Plan:
- Reset/idle: rst high 2 cycles then low → wready=1, out_v=0, busy=0, out_r all 0.
- Single vector: write words (i*100)+1 for i=0..7 back-to-back, array_rdy=1 → wready=0 one cycle after last accept; out_v[i] pulses alone, i cycles after out_v[0], with out_r[i]=i*100+1.
- Stall: same vector, array_rdy=0 for 3 cycles starting when out_v[3]=1 → out_v[3] and out_r[3]=301 hold 3 cycles; lanes 4..7 then follow at offsets 1..4.
- Backpressure: hold array_rdy=0 before vector 1 completes, keep wvalid=1 with vector 2 words 1000..1007 → wready stays 0 and no words are lost; after array_rdy rises, all 16 words appear in order on lanes 0..7.
- Reset mid-operation: rst at the edge where out_v[2]=1 → next cycle all out_v=0, cnt=0, wready=1; the next vector 5..12 emits cleanly.
- ROW_IN_FLUSH_EN: write 3 words 7,8,9 then flush → lanes 0..2 emit 7,8,9 with skew; out_v[3..7] never assert; busy drops after lane 2 drains.

Source files
------------

// File: rtl/systola_pkg.sv
// systola_pkg: definitions shared by the systolic-array edge controllers.
//   - default array geometry (row count, word width)
//   - row-input controller state encoding
//   - word type at the default width
package systola_pkg;
    localparam int DW_DEF    = 32;
    localparam int NROWS_DEF = 8;

    typedef enum logic {
        FILL   = 1'b0,
        LAUNCH = 1'b1
    } row_in_state_e;

    typedef logic [DW_DEF-1:0] word_t;
endpackage

// File: rtl/row_input_ctrl_skew_line.sv
// skew_line: one lane of the row-input skew pipeline. A DEPTH-register delay
// line carrying data and a valid bit, advancing only when adv is high.
//   clk, rst   clock, synchronous active-high reset (clears data and valid)
//   adv        advance enable; low holds every stage
//   din, vin   data/valid shifted into stage 0
//   dout, vout final stage
module skew_line
    import systola_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic [DW-1:0] din,
    input  logic          vin,
    output logic [DW-1:0] dout,
    output logic          vout
);
    logic [DEPTH-1:0][DW-1:0] d_pipe;
    logic [DEPTH-1:0]         vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_pipe   <= '0;
            vld_pipe <= '0;
        end else if (adv) begin
            d_pipe[0]   <= din;
            vld_pipe[0] <= vin;
            for (int k = 1; k < DEPTH; k++) begin
                d_pipe[k]   <= d_pipe[k-1];
                vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    end

    assign dout = d_pipe[DEPTH-1];
    assign vout = vld_pipe[DEPTH-1];
endmodule

// File: rtl/row_input_ctrl.sv
// row_input_ctrl: packs NROWS serial words into a row vector and launches it
// into the systolic array's left edge with diagonal skew (lane i lags lane 0
// by i advancing cycles).
//   clk, rst    clock, synchronous active-high reset
//   wvalid/win  serial write word; wready accepts it (registered, FILL only)
//   array_rdy   array advancing; low freezes the skew pipeline
//   out_r/out_v per-lane data/valid, lane i = element i
//   busy        partial vector, pending vector, or any lane valid
//   flush       (only with ROW_IN_FLUSH_EN) launch a partial vector,
//               zero-padding the missing lanes with their valids held low
module row_input_ctrl
    import systola_pkg::*;
#(
    parameter int NROWS = NROWS_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wvalid,
    input  logic [DW-1:0]               win,
    output logic                        wready,
    input  logic                        array_rdy,
    output logic [0:NROWS-1][DW-1:0]    out_r,
    output logic [NROWS-1:0]            out_v,
`ifdef ROW_IN_FLUSH_EN
    input  logic                        flush,
`endif
    output logic                        busy
);
    localparam int CW = $clog2(NROWS + 1);

    row_in_state_e             state;
    logic [CW-1:0]             cnt;
    logic [NROWS-1:0][DW-1:0]  staging;
    logic [NROWS-1:0]          lane_en;   // which lanes launch with valid=1

    logic          accept;
    logic          launch;
    logic          flush_go;
    logic [CW-1:0] cnt_nxt;

    // wready is a register that is 1 exactly in FILL, so accept never
    // depends combinationally on anything but wvalid and state.
    assign accept  = wvalid && wready;
    assign launch  = (state == LAUNCH) && array_rdy;
    assign cnt_nxt = cnt + CW'(accept);

`ifdef ROW_IN_FLUSH_EN
    assign flush_go = flush && (state == FILL) && (cnt != '0);
`else
    assign flush_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            wready  <= 1'b1;
            cnt     <= '0;
            staging <= '0;
            lane_en <= '0;
        end else begin
            case (state)
                FILL: begin
                    for (int i = 0; i < NROWS; i++) begin
                        if (accept && cnt == CW'(i))
                            staging[i] <= win;
                        // A same-edge word lands first; everything past it pads to 0.
                        else if (flush_go && CW'(i) >= cnt_nxt)
                            staging[i] <= '0;
                    end
                    cnt <= cnt_nxt;
                    if ((accept && cnt == CW'(NROWS-1)) || flush_go) begin
                        state  <= LAUNCH;
                        wready <= 1'b0;
                        for (int i = 0; i < NROWS; i++)
                            lane_en[i] <= CW'(i) < cnt_nxt;
                    end
                end
                LAUNCH: begin
                    if (array_rdy) begin
                        state  <= FILL;
                        wready <= 1'b1;
                        cnt    <= '0;
                    end
                end
                default: begin
                    state  <= FILL;
                    wready <= 1'b1;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Lane i is i+1 registers deep, which produces the diagonal skew.
    for (genvar i = 0; i < NROWS; i++) begin : g_lane
        skew_line #(
            .DEPTH (i + 1),
            .DW    (DW)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .adv  (array_rdy),
            .din  (staging[i]),
            .vin  (launch && lane_en[i]),
            .dout (out_r[i]),
            .vout (out_v[i])
        );
    end

    assign busy = (cnt != '0) || (state == LAUNCH) || (|out_v);
endmodule

// File: tb/tb_row_input_ctrl.sv
module tb_row_input_ctrl;
    localparam int NROWS = 8;
    localparam int DW    = 32;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       wvalid = 1'b0;
    logic [DW-1:0]              win = '0;
    logic                       wready;
    logic                       array_rdy = 1'b1;
    logic [0:NROWS-1][DW-1:0]   out_r;
    logic [NROWS-1:0]           out_v;
    logic                       busy;
    logic                       flush = 1'b0;

    row_input_ctrl #(.NROWS(NROWS), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wvalid    (wvalid),
        .win       (win),
        .wready    (wready),
        .array_rdy (array_rdy),
        .out_r     (out_r),
        .out_v     (out_v),
`ifdef ROW_IN_FLUSH_EN
        .flush     (flush),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [DW-1:0] d;
        int            vid;
    } item_t;

    item_t         lane_q[NROWS][$];   // expected emissions per lane
    logic [DW-1:0] part[$];            // words of the vector being collected
    int            launch_at[int];     // advancing-edge index of each vector's launch
    bit            waiting = 0;        // complete vector not yet launched
    bit            armed   = 0;
    int            cur_vid = 0;
    int            next_vid = 0;
    int            adv_cnt = 0;        // index of the upcoming advancing edge

    // Everything here is evaluated mid-cycle: first the DUT outputs are
    // compared with the model's pre-edge view, then the model steps across
    // the upcoming edge using the inputs that edge will sample.
    always @(negedge clk) begin
        item_t it;
        bit    hs, fl;
        int    inflight;
        if (armed) begin
            inflight = 0;
            for (int i = 0; i < NROWS; i++) inflight += lane_q[i].size();
            check("wready", 64'(wready), 64'(!waiting));
            check("busy", 64'(busy), 64'((part.size() > 0) || waiting || (inflight > 0)));
            if (array_rdy) begin
                for (int i = 0; i < NROWS; i++) begin
                    if (out_v[i]) begin
                        if (lane_q[i].size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_valid lane %0d: got out_v=1 expected 0 at %0t", i, $time);
                        end else begin
                            it = lane_q[i].pop_front();
                            check($sformatf("lane%0d_data", i), 64'(out_r[i]), 64'(it.d));
                            if (launch_at.exists(it.vid))
                                check($sformatf("lane%0d_skew", i), 64'(adv_cnt),
                                      64'(launch_at[it.vid] + 1 + i));
                        end
                    end
                end
            end
        end
        if (rst) begin
            for (int i = 0; i < NROWS; i++) lane_q[i].delete();
            part.delete();
            waiting = 0;
            armed   = 1;
        end else if (armed) begin
            hs = wvalid && !waiting;
            fl = flush && !waiting && (part.size() > 0);
            if (array_rdy) begin
                if (waiting) begin
                    launch_at[cur_vid] = adv_cnt;
                    waiting = 0;
                end
                adv_cnt++;
            end
            if (hs) part.push_back(win);
            if (part.size() == NROWS || fl) begin
                cur_vid = next_vid++;
                for (int i = 0; i < part.size(); i++) lane_q[i].push_back('{d: part[i], vid: cur_vid});
                part.delete();
                waiting = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_rdy = 0;
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 array_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic write_word(input logic [DW-1:0] d);
        int n = 0;
        bit hs;
        win = d;
        wvalid = 1'b1;
        do begin
            hs = wready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) begin
            checks++; errors++;
            $display("FAIL write_timeout: got no accept expected accept of %0h", d);
        end
        wvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 300);
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic wait_lane(input int lane);
        int n = 0;
        while (!out_v[lane] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("wait_lane%0d", lane), 64'(out_v[lane]), 64'd1);
    endtask

    initial begin
        // reset / idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_wready", 64'(wready), 64'd1);
        check("rst_out_v", 64'(out_v), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < NROWS; i++) check($sformatf("rst_out_r%0d", i), 64'(out_r[i]), 64'd0);

        // single vector, back-to-back
        for (int i = 0; i < NROWS; i++) write_word(DW'(i * 100 + 1));
        wait_idle();

        // stall with lane 3 showing
        fork
            for (int i = 0; i < NROWS; i++) write_word(DW'(i * 100 + 1));
            begin
                wait_lane(3);
                array_rdy = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    check("stall_v3", 64'(out_v[3]), 64'd1);
                    check("stall_r3", 64'(out_r[3]), 64'd301);
                end
                array_rdy = 1'b1;
            end
        join
        wait_idle();

        // backpressure: array stalled while two vectors are offered
        array_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < NROWS; i++) write_word(DW'(500 + i));
                for (int i = 0; i < NROWS; i++) write_word(DW'(1000 + i));
            end
            begin
                repeat (20) @(posedge clk);
                #1 array_rdy = 1'b1;
            end
        join
        wait_idle();

        // reset mid-skew
        fork
            for (int i = 0; i < NROWS; i++) write_word(DW'(20 + i));
            begin
                wait_lane(2);
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("midrst_out_v", 64'(out_v), 64'd0);
                check("midrst_wready", 64'(wready), 64'd1);
                check("midrst_busy", 64'(busy), 64'd0);
            end
        join
        for (int i = 0; i < NROWS; i++) write_word(DW'(5 + i));
        wait_idle();

`ifdef ROW_IN_FLUSH_EN
        write_word(7); write_word(8); write_word(9);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_idle();
`endif

        // randomized traffic with random stalls and gaps
        rand_rdy = 1;
        for (int i = 0; i < 5 * NROWS; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            write_word($urandom());
        end
        rand_rdy = 0;
        @(posedge clk); #1;
        array_rdy = 1'b1;
        wait_idle();

        begin
            int left = 0;
            for (int i = 0; i < NROWS; i++) left += lane_q[i].size();
            check("drained", 64'(left), 64'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
